// File: rtl/ex_mem_latch_pkg.sv
// Shared pipeline constants for the EX/MEM stage latch.
package ex_mem_latch_pkg;

  localparam int unsigned DW_DEFAULT  = 16;
  localparam int unsigned RW_DEFAULT  = 3;
  localparam int unsigned STALL_CNT_W = 16;

  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } latch_state_e;

  // Increment that sticks at the maximum instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] cnt);
    return (cnt == STALL_CNT_MAX) ? cnt : cnt + STALL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ex_mem_latch_dff_en.sv
// Enabled flop with synchronous active-high reset to zero.
module dff_en #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // Clear on reset, otherwise load when enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst)     o_q <= '0;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline latch with memory back-pressure, deferred flush and stall counter.
module ex_mem_latch
  import ex_mem_latch_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned RW = RW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          ex_ALU_res,
  input  logic [DW-1:0]          ex_read2data,
  input  logic                   ex_memWrite,
  input  logic                   ex_memRead,
  input  logic                   ex_regWrite,
  input  logic                   ex_memtoReg,
  input  logic [RW-1:0]          ex_writeReg,
  input  logic                   ex_halt,
  input  logic                   ex_valid,
  input  logic                   flush,
  input  logic                   mem_stall,
  output logic [DW-1:0]          ALU_res,
  output logic [DW-1:0]          read2data,
  output logic                   memWrite,
  output logic                   memRead,
  output logic                   regWrite,
  output logic                   memtoReg,
  output logic [RW-1:0]          writeReg,
  output logic                   halt,
  output logic                   valid,
  output logic                   ex_stall,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  latch_state_e           r_state;
  logic                   r_flush_pend;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic          w_capture;
  logic          w_bubble;
  logic [DW-1:0] w_alu_d;
  logic [DW-1:0] w_r2_d;
  logic [RW-1:0] w_wreg_d;
  logic          w_mw_d;
  logic          w_mr_d;
  logic          w_rw_d;
  logic          w_m2r_d;
  logic          w_halt_d;
  logic          w_valid_d;

  // Capture whenever memory is not busy; a killed or empty slot loads zeros.
  assign w_capture = ~mem_stall;
  assign w_bubble  = ~ex_valid | flush | r_flush_pend;

  assign w_alu_d   = w_bubble ? '0   : ex_ALU_res;
  assign w_r2_d    = w_bubble ? '0   : ex_read2data;
  assign w_wreg_d  = w_bubble ? '0   : ex_writeReg;
  assign w_mw_d    = w_bubble ? 1'b0 : ex_memWrite;
  assign w_mr_d    = w_bubble ? 1'b0 : ex_memRead;
  assign w_rw_d    = w_bubble ? 1'b0 : ex_regWrite;
  assign w_m2r_d   = w_bubble ? 1'b0 : ex_memtoReg;
  assign w_halt_d  = w_bubble ? 1'b0 : ex_halt;
  assign w_valid_d = w_bubble ? 1'b0 : ex_valid;

  dff_en #(.W(DW)) u_alu   (.i_clk(clk), .i_rst(rst), .i_en(w_capture), .i_d(w_alu_d),   .o_q(ALU_res));
  dff_en #(.W(DW)) u_r2    (.i_clk(clk), .i_rst(rst), .i_en(w_capture), .i_d(w_r2_d),    .o_q(read2data));
  dff_en #(.W(RW)) u_wreg  (.i_clk(clk), .i_rst(rst), .i_en(w_capture), .i_d(w_wreg_d),  .o_q(writeReg));
  dff_en #(.W(1))  u_mw    (.i_clk(clk), .i_rst(rst), .i_en(w_capture), .i_d(w_mw_d),    .o_q(memWrite));
  dff_en #(.W(1))  u_mr    (.i_clk(clk), .i_rst(rst), .i_en(w_capture), .i_d(w_mr_d),    .o_q(memRead));
  dff_en #(.W(1))  u_rw    (.i_clk(clk), .i_rst(rst), .i_en(w_capture), .i_d(w_rw_d),    .o_q(regWrite));
  dff_en #(.W(1))  u_m2r   (.i_clk(clk), .i_rst(rst), .i_en(w_capture), .i_d(w_m2r_d),   .o_q(memtoReg));
  dff_en #(.W(1))  u_halt  (.i_clk(clk), .i_rst(rst), .i_en(w_capture), .i_d(w_halt_d),  .o_q(halt));
  dff_en #(.W(1))  u_valid (.i_clk(clk), .i_rst(rst), .i_en(w_capture), .i_d(w_valid_d), .o_q(valid));

  // Run/hold sequencing, pending-flush tracking and saturating stall count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_flush_pend <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      if (mem_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      case (r_state)
        ST_RUN: begin
          if (mem_stall) begin
            r_state <= ST_HOLD;
            if (flush) r_flush_pend <= 1'b1;
          end else begin
            r_flush_pend <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!mem_stall) begin
            r_state      <= ST_RUN;
            r_flush_pend <= 1'b0;
          end else if (flush) begin
            r_flush_pend <= 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign ex_stall  = mem_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Randomized and directed bench for ex_mem_latch against a cycle-level reference model.
module tb_ex_mem_latch;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;
  localparam int unsigned PW = 2*DW + RW + 6;

  logic          clk;
  logic          rst;
  logic [DW-1:0] ex_ALU_res, ex_read2data;
  logic          ex_memWrite, ex_memRead, ex_regWrite, ex_memtoReg;
  logic [RW-1:0] ex_writeReg;
  logic          ex_halt, ex_valid, flush, mem_stall;
  logic [DW-1:0] ALU_res, read2data;
  logic          memWrite, memRead, regWrite, memtoReg;
  logic [RW-1:0] writeReg;
  logic          halt, valid, ex_stall;
  logic [15:0]   stall_cnt;

  ex_mem_latch #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .ex_ALU_res(ex_ALU_res), .ex_read2data(ex_read2data),
    .ex_memWrite(ex_memWrite), .ex_memRead(ex_memRead),
    .ex_regWrite(ex_regWrite), .ex_memtoReg(ex_memtoReg),
    .ex_writeReg(ex_writeReg), .ex_halt(ex_halt), .ex_valid(ex_valid),
    .flush(flush), .mem_stall(mem_stall),
    .ALU_res(ALU_res), .read2data(read2data),
    .memWrite(memWrite), .memRead(memRead),
    .regWrite(regWrite), .memtoReg(memtoReg),
    .writeReg(writeReg), .halt(halt), .valid(valid),
    .ex_stall(ex_stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the pipeline slot contents as one packed word, plus pending flush and count.
  logic [PW-1:0] m_slot;
  logic          m_pend;
  int            m_cnt;

  function automatic logic [PW-1:0] ex_word();
    return {ex_ALU_res, ex_read2data, ex_memWrite, ex_memRead, ex_regWrite,
            ex_memtoReg, ex_writeReg, ex_halt, ex_valid};
  endfunction

  function automatic logic [PW-1:0] out_word();
    return {ALU_res, read2data, memWrite, memRead, regWrite,
            memtoReg, writeReg, halt, valid};
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_slot = '0;
      m_pend = 1'b0;
      m_cnt  = 0;
    end else if (mem_stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (flush) m_pend = 1'b1;
    end else begin
      m_slot = (!ex_valid || flush || m_pend) ? '0 : ex_word();
      m_pend = 1'b0;
    end
    #1;
  endtask

  task automatic rand_ex();
    ex_ALU_res   = DW'($urandom);
    ex_read2data = DW'($urandom);
    ex_memWrite  = 1'($urandom);
    ex_memRead   = 1'($urandom);
    ex_regWrite  = 1'($urandom);
    ex_memtoReg  = 1'($urandom);
    ex_writeReg  = RW'($urandom);
    ex_halt      = 1'($urandom);
    ex_valid     = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_stall = 1'b0; flush = 1'b0;
    rand_ex();
    tick();
    tick();
    checks++;
    if (out_word() !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h want=0", out_word());
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got=%h want=0", stall_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    rand_ex();
    ex_ALU_res = 16'h1234; ex_memRead = 1'b1; ex_memWrite = 1'b0;
    tick();
    checks++;
    if (ALU_res !== 16'h1234 || memRead !== 1'b1 || valid !== 1'b1) begin
      failures++; $display("FAIL stream_capture got alu=%h rd=%b v=%b want alu=1234 rd=1 v=1",
                           ALU_res, memRead, valid);
    end
    checks++;
    if (out_word() !== m_slot) begin
      failures++; $display("FAIL stream_model got=%h want=%h", out_word(), m_slot);
    end
  endtask

  task automatic test_stall_hold();
    logic [PW-1:0] held;
    logic [15:0]   cnt0;
    rand_ex();
    tick();
    held = ex_word();
    cnt0 = stall_cnt;
    mem_stall = 1'b1;
    #1;
    checks++;
    if (ex_stall !== 1'b1) begin
      failures++; $display("FAIL stall_comb got=%b want=1", ex_stall);
    end
    for (int i = 0; i < 4; i++) begin
      rand_ex();
      tick();
      checks++;
      if (out_word() !== held || ex_stall !== 1'b1) begin
        failures++; $display("FAIL stall_hold cyc=%0d got=%h st=%b want=%h st=1",
                             i, out_word(), ex_stall, held);
      end
    end
    checks++;
    if (stall_cnt !== 16'(cnt0 + 16'd4)) begin
      failures++; $display("FAIL stall_cnt got=%h want=%h", stall_cnt, 16'(cnt0 + 16'd4));
    end
    mem_stall = 1'b0;
    rand_ex();
    held = ex_word();
    tick();
    checks++;
    if (out_word() !== held || ex_stall !== 1'b0) begin
      failures++; $display("FAIL stall_release got=%h want=%h", out_word(), held);
    end
  endtask

  task automatic test_deferred_flush();
    logic [PW-1:0] held;
    logic [PW-1:0] nxt;
    rand_ex();
    ex_memRead = 1'b1; ex_memWrite = 1'b0;
    tick();
    held = ex_word();
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      rand_ex();
      tick();
      checks++;
      if (out_word() !== held || memRead !== 1'b1) begin
        failures++; $display("FAIL dflush_hold cyc=%0d got=%h want=%h", i, out_word(), held);
      end
    end
    flush = 1'b0; mem_stall = 1'b0;
    rand_ex(); ex_regWrite = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0 || regWrite !== 1'b0 || out_word() !== '0) begin
      failures++; $display("FAIL dflush_bubble got=%h want=0", out_word());
    end
    rand_ex();
    nxt = ex_word();
    tick();
    checks++;
    if (out_word() !== nxt) begin
      failures++; $display("FAIL dflush_after got=%h want=%h", out_word(), nxt);
    end
  endtask

  task automatic test_simul_flush();
    rand_ex();
    ex_memWrite = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (memWrite !== 1'b0 || valid !== 1'b0) begin
      failures++; $display("FAIL simul_flush got mw=%b v=%b want 0/0", memWrite, valid);
    end
    rand_ex();
    tick();
    checks++;
    if (out_word() !== m_slot || valid !== 1'b1) begin
      failures++; $display("FAIL simul_flush_nopend got=%h want=%h", out_word(), m_slot);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [PW-1:0] nxt;
    rand_ex(); ex_memWrite = 1'b1;
    tick();
    mem_stall = 1'b1;
    tick();
    tick();
    checks++;
    if (memWrite !== 1'b1) begin
      failures++; $display("FAIL rst_hold_pre got mw=%b want=1", memWrite);
    end
    rst = 1'b1; flush = 1'b1;
    tick();
    checks++;
    if (out_word() !== '0 || stall_cnt !== 16'd0) begin
      failures++; $display("FAIL rst_hold got=%h cnt=%h want=0 cnt=0", out_word(), stall_cnt);
    end
    rst = 1'b0; flush = 1'b0; mem_stall = 1'b0;
    rand_ex();
    nxt = ex_word();
    tick();
    checks++;
    if (out_word() !== nxt || stall_cnt !== 16'd0) begin
      failures++; $display("FAIL rst_first_capture got=%h want=%h", out_word(), nxt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_ex();
      ex_valid  = ($urandom_range(0, 4) != 0);
      flush     = ($urandom_range(0, 5) == 0);
      mem_stall = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 60) == 0);
      tick();
      checks++;
      if (out_word() !== m_slot || stall_cnt !== 16'(m_cnt)) begin
        failures++; $display("FAIL random cyc=%0d got=%h cnt=%h want=%h cnt=%h",
                             i, out_word(), stall_cnt, m_slot, 16'(m_cnt));
      end
    end
    rst = 1'b0; flush = 1'b0; mem_stall = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_stall = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      failures++; $display("FAIL sat_pre got=%h want=FFFE", stall_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (stall_cnt !== 16'hFFFF || stall_cnt !== 16'(m_cnt)) begin
        failures++; $display("FAIL sat_hold cyc=%0d got=%h want=FFFF", i, stall_cnt);
      end
    end
    mem_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
    ex_ALU_res = '0; ex_read2data = '0; ex_memWrite = 1'b0; ex_memRead = 1'b0;
    ex_regWrite = 1'b0; ex_memtoReg = 1'b0; ex_writeReg = '0; ex_halt = 1'b0; ex_valid = 1'b0;
    m_slot = '0; m_pend = 1'b0; m_cnt = 0;
    test_reset();
    test_stream();
    test_stall_hold();
    test_deferred_flush();
    test_simul_flush();
    test_reset_mid_hold();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
